// File: rtl/ir_key_queue_pkg.sv
// Shared constants, FSM encoding and key helpers for the IR key queue.
package ir_pkg;

  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;
  localparam logic [CHAR_W-1:0] KEY_MAX = 8'h09;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_HOLDOFF_CYC = 5000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sup_state_t;

  function automatic logic key_mappable(input logic [CHAR_W-1:0] code);
    return code <= KEY_MAX;
  endfunction

  function automatic logic [CHAR_W-1:0] key_to_ascii(input logic [CHAR_W-1:0] code);
    return ASCII_ZERO + code;
  endfunction

endpackage

// File: rtl/ir_key_queue_if.sv
// Key-code input and character output handshake of the IR key queue.
interface ir_key_queue_if;
  import ir_pkg::*;

  logic [CHAR_W-1:0] code_in;
  logic              code_valid;
  logic [CHAR_W-1:0] char_out;
  logic              char_valid;
  logic              char_ready;

  modport master (
    output code_in, code_valid, char_ready,
    input  char_out, char_valid
  );

  modport slave (
    input  code_in, code_valid, char_ready,
    output char_out, char_valid
  );

endinterface

// File: rtl/ir_char_fifo.sv
// First-word-fall-through character FIFO; storage is not reset, pointers wrap naturally.
module ir_char_fifo
  import ir_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [CHAR_W-1:0]        wdata,
  output logic [CHAR_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ir_key_queue.sv
// IR key to ASCII queue with repeat suppression.
//   state   | meaning
//   ST_IDLE | no recent key; next mappable key is always queued
//   ST_HOLD | within holdoff of last key; repeats of last_code are dropped
module ir_key_queue
  import ir_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int HOLDOFF_CYC = DEFAULT_HOLDOFF_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  ir_key_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow
);

  localparam int CW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYC - 1);

  sup_state_t        state, state_nxt;
  logic [CHAR_W-1:0] last_code, last_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              key_ok;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CHAR_W-1:0] char_in;

  assign key_ok         = bus.code_valid && key_mappable(bus.code_in);
  assign char_in        = key_to_ascii(bus.code_in);
  assign bus.char_valid = !empty;
  assign pop            = bus.char_valid && bus.char_ready;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_code;
    cnt_nxt   = cnt;
    push      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_ok) begin
          push      = 1'b1;
          last_nxt  = bus.code_in;
          cnt_nxt   = '0;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (key_ok) begin
          push     = (bus.code_in != last_code);
          last_nxt = bus.code_in;
          cnt_nxt  = '0;
        end else if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_IDLE;
      last_code <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      last_code <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_code <= last_nxt;
      cnt       <= cnt_nxt;
      // Dropped key: the FSM above still advances as if it had been queued.
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  ir_char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (char_in),
    .rdata (bus.char_out),
    .full  (full),
    .empty (empty),
    .count (fill_level)
  );

endmodule

// File: tb/tb_ir_key_queue.sv
// Scoreboard bench: a time-based suppression/queue model feeds expected characters, a monitor checks outputs.
module tb_ir_key_queue;

  localparam int DEPTH = 8;
  localparam int HOLD  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] fill_level;
  logic       overflow;

  ir_key_queue_if bus();

  ir_key_queue #(.DEPTH(DEPTH), .HOLDOFF_CYC(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .fill_level (fill_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state (written only by the model process)
  logic [7:0] exp_q[$];
  int         flush_idx = 0;
  int         m_count = 0;
  bit         m_ovf = 1'b0;
  bit         m_hold = 1'b0;
  logic [7:0] m_last = 8'h00;
  int         m_t0 = 0;

  // monitor state
  int         rd_idx = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: a key is suppressed only if it repeats the last mappable
  // key and arrives no more than HOLD cycles after it.
  initial begin
    int  cyc;
    bit  pop;
    bit  push;
    forever begin
      @(posedge clk or posedge rst_n);
      cyc = int'($time / 10);
      if (rst_n || clear) begin
        flush_idx = exp_q.size();
        m_count   = 0;
        m_ovf     = 1'b0;
        m_hold    = 1'b0;
        m_last    = 8'h00;
      end else begin
        pop  = (m_count > 0) && bus.char_ready;
        push = 1'b0;
        if (bus.code_valid && bus.code_in <= 8'h09) begin
          if (!(m_hold && (cyc - m_t0 <= HOLD) && bus.code_in == m_last)) push = 1'b1;
          m_last = bus.code_in;
          m_t0   = cyc;
          m_hold = 1'b1;
        end
        if (push) begin
          if (m_count < DEPTH || pop) begin
            exp_q.push_back(8'h30 + bus.code_in);
            m_count++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (pop) m_count--;
      end
    end
  end

  // Monitor: compares DUT outputs away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_idx < flush_idx) rd_idx = flush_idx;
      chk("char_valid", int'(bus.char_valid), int'(m_count != 0));
      chk("fill_level", int'(fill_level), m_count);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (bus.char_valid && rd_idx < exp_q.size()) begin
        chk("char_out", int'(bus.char_out), int'(exp_q[rd_idx]));
        if (bus.char_ready) rd_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_key(input logic [7:0] code);
    bus.code_in    = code;
    bus.code_valid = 1'b1;
    tick();
    bus.code_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.char_ready = 1'b1;
    repeat (n) tick();
    bus.char_ready = 1'b0;
  endtask

  initial begin
    bus.code_in    = 8'h00;
    bus.code_valid = 1'b0;
    bus.char_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();

    // single key becomes visible the next cycle
    pulse_key(8'h03);
    tick();
    pulse_clear();

    // repeat inside holdoff suppressed, after holdoff queued
    pulse_key(8'h05);
    repeat (9) tick();
    pulse_key(8'h05);
    repeat (19) tick();
    pulse_key(8'h05);
    tick();
    drain(4);
    pulse_clear();

    // unmappable code ignored
    pulse_key(8'h01);
    pulse_key(8'h02);
    pulse_key(8'h1C);
    tick();
    drain(3);
    pulse_clear();

    // overflow with nine distinct keys, then drain order and clear
    for (int k = 0; k < 9; k++) pulse_key(8'(k));
    tick();
    drain(10);
    tick();
    pulse_clear();
    tick();

    // full FIFO with simultaneous pop and push
    for (int k = 0; k < 8; k++) pulse_key(8'(k));
    bus.char_ready = 1'b1;
    pulse_key(8'h09);
    bus.char_ready = 1'b0;
    tick();
    drain(9);
    pulse_clear();

    // reset while holding with entries queued, same key accepted afterwards
    for (int k = 4; k < 8; k++) pulse_key(8'(k));
    rst_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    pulse_key(8'h07);
    tick();
    drain(2);
    pulse_clear();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.char_ready = ($urandom_range(0, 1) == 1);
      clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.code_valid = 1'b1;
        bus.code_in = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 15))
                                                  : 8'($urandom_range(0, 2));
      end else begin
        bus.code_valid = 1'b0;
        bus.code_in = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 499) == 0) rst_n = 1'b1;
      else rst_n = 1'b0;
      tick();
      if (i % 100 == 99) begin
        bus.code_valid = 1'b0;
        clear = 1'b0;
        rst_n = 1'b0;
        repeat (HOLD + $urandom_range(0, 4)) tick();
      end
    end
    bus.code_valid = 1'b0;
    clear = 1'b0;
    rst_n = 1'b0;
    drain(DEPTH + 2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_key_queue.md
IR_KEY_QUEUE -- requirements
Module: ir_key_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter HOLDOFF_CYC, default 5000000, repeat-suppression window in clk cycles (100 ms at 50 MHz).
REQ-003 clk  input  1  single clock, rising edge, 50 MHz.
REQ-004 rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-005 code_in  input  8  decoded IR key code from the IR receiver.
REQ-006 code_valid  input  1  one-cycle pulse, code_in valid.
REQ-007 clear  input  1  synchronous flush.
REQ-008 char_out  output  8  ASCII character at FIFO head, to LCD writer.
REQ-009 char_valid  output  1  char_out valid (FIFO not empty).
REQ-010 char_ready  input  1  consumer accepts char_out.
REQ-011 fill_level  output  log2(DEPTH)+1  current entry count.
REQ-012 overflow  output  1  sticky, key dropped because FIFO was full.

Function
REQ-013 Map code 0x00..0x09 -> ASCII 0x30..0x39; any other code SHALL be discarded with no state change.
REQ-014 Suppression FSM states IDLE, HOLD; reset state IDLE; last_code register, reset 0x00.
REQ-015 IDLE + valid mappable code -> push, last_code <= code_in, holdoff counter <= 0, go HOLD.
REQ-016 HOLD + valid mappable code equal to last_code -> no push, counter restarts at 0, stay HOLD.
REQ-017 HOLD + valid mappable code different from last_code -> push, last_code updated, counter restarts, stay HOLD.
REQ-018 HOLD, counter reaches HOLDOFF_CYC-1 with no code_valid -> IDLE.
REQ-019 Push when FIFO full and no pop in same cycle -> entry dropped, overflow <= 1; FSM/last_code still update as if accepted.
REQ-020 Pop occurs when char_valid && char_ready; char_out is first-word-fall-through (head visible combinationally from storage).
REQ-021 Push and pop in same cycle: both occur, including when full; fill_level unchanged.
REQ-022 Empty FIFO: push at cycle N -> char_valid = 1 at N+1; no pop possible at N.
REQ-023 Read/write pointers wrap modulo DEPTH; fill_level range 0..DEPTH.
REQ-024 clear: FIFO emptied, overflow <= 0, FSM <= IDLE, last_code <= 0x00; clear overrides push and pop in same cycle.
REQ-025 overflow remains 1 until clear or reset.

Reset
REQ-026 While rst_n = 1: char_valid = 0, fill_level = 0, overflow = 0, pointers = 0, FSM = IDLE, counter = 0, last_code = 0x00.
REQ-027 Reset mid-operation discards all queued characters; no pop is reported on deassertion.
REQ-028 FIFO storage array SHALL NOT be reset; char_out is don't-care while char_valid = 0.

Structure
REQ-029 Shared package ir_pkg: ASCII_ZERO = 8'h30, KEY_MAX = 8'h09, default DEPTH, default HOLDOFF_CYC.
REQ-030 One sub-module, ir_char_fifo: synchronous FWFT FIFO with push, pop, clear, full, empty, count; suppression FSM and mapping stay in ir_key_queue.

Verification
REQ-031 HOLDOFF_CYC=16: code 0x03 pulse, char_ready=0 -> next cycle char_valid=1, char_out=0x33, fill_level=1.
REQ-032 Code 0x05 pulsed at cycles 0 and 10, HOLDOFF_CYC=16 -> one entry 0x35; re-pulse at cycle 30 -> second 0x35 queued.
REQ-033 Codes 0x01, 0x02 back-to-back, then 0x1C -> FIFO holds 0x31, 0x32; 0x1C ignored, fill_level=2.
REQ-034 DEPTH=8, char_ready=0, 9 distinct keys -> fill_level=8, overflow=1, drained order 0x30..0x37; pulse clear -> overflow=0, fill_level=0.
REQ-035 Full FIFO, char_ready=1 and new key same cycle -> pop and push both occur, fill_level stays 8, overflow stays 0.
REQ-036 rst_n asserted with 4 entries queued while HOLD -> char_valid=0, fill_level=0, FSM IDLE; same key after release queued immediately.
